// File: rtl/instr_fetch_ctrl_if.sv
// Fetch-side bus bundle: fetch control, instruction memory port and the decode handshake.
interface instr_fetch_ctrl_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int FIFO_DEPTH  = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                   fetch_en;
  logic                   redirect_valid;
  logic [ADDR_WIDTH-1:0]  redirect_pc;
  logic [ADDR_WIDTH-1:0]  F_PC;
  logic [INSTR_WIDTH-1:0] im_instr;
  logic                   out_valid;
  logic [INSTR_WIDTH-1:0] out_instr;
  logic [ADDR_WIDTH-1:0]  out_pc;
  logic                   out_ready;
  logic                   halted;
  logic [CW-1:0]          fifo_count;

  modport master (
    input  fetch_en, redirect_valid, redirect_pc, im_instr, out_ready,
    output F_PC, out_valid, out_instr, out_pc, halted, fifo_count
  );

  modport slave (
    output fetch_en, redirect_valid, redirect_pc, im_instr, out_ready,
    input  F_PC, out_valid, out_instr, out_pc, halted, fifo_count
  );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: drives F_PC, buffers {pc, instr} in a prefetch FIFO,
// and handles backpressure, redirect flush, fetch enable and halt-on-sentinel.
//
// state   | meaning
// IDLE    | fetch disabled, F_PC holds, FIFO drains
// FETCH   | one capture per cycle while FIFO has room (or is popping)
// HALTED  | sentinel captured; waits for redirect, FIFO drains
module instr_fetch_ctrl #(
  parameter int                     ADDR_WIDTH  = 32,
  parameter int                     INSTR_WIDTH = 32,
  parameter int                     FIFO_DEPTH  = 4,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC    = '0,
  parameter logic [INSTR_WIDTH-1:0] HALT_WORD   = 32'hFFFF_FFFF
) (
  input logic               clk,
  input logic               reset_n,
  instr_fetch_ctrl_if.master bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, HALTED} state_t;

  state_t                 state;
  logic [ADDR_WIDTH-1:0]  f_pc;
  logic                   halted;
  logic [CW-1:0]          count;
  logic [PW-1:0]          rd_ptr;
  logic [PW-1:0]          wr_ptr;
  logic [ADDR_WIDTH-1:0]  mem_pc    [FIFO_DEPTH];
  logic [INSTR_WIDTH-1:0] mem_instr [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]  last_pc;
  logic [INSTR_WIDTH-1:0] last_instr;

  logic out_valid;
  logic pop;
  logic push;

  assign out_valid = (count != '0);
  assign pop       = out_valid && bus.out_ready && !bus.redirect_valid;
  assign push      = (state == FETCH) && !bus.redirect_valid &&
                     ((count < CW'(FIFO_DEPTH)) || pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      f_pc       <= RESET_PC;
      halted     <= 1'b0;
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      last_pc    <= '0;
      last_instr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_pc[i]    <= '0;
        mem_instr[i] <= '0;
      end
    end else if (bus.redirect_valid) begin
      // Flush beats everything, including a halt word on im_instr this cycle.
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      f_pc   <= bus.redirect_pc;
      halted <= 1'b0;
      state  <= bus.fetch_en ? FETCH : IDLE;
    end else begin
      if (push) begin
        mem_pc[wr_ptr]    <= f_pc;
        mem_instr[wr_ptr] <= bus.im_instr;
        wr_ptr            <= wr_ptr + PW'(1);
        f_pc              <= f_pc + ADDR_WIDTH'(1);
      end
      if (pop) begin
        rd_ptr     <= rd_ptr + PW'(1);
        last_pc    <= mem_pc[rd_ptr];
        last_instr <= mem_instr[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      case (state)
        IDLE: begin
          if (bus.fetch_en) state <= FETCH;
        end
        FETCH: begin
          if (push && (bus.im_instr == HALT_WORD)) begin
            state  <= HALTED;
            halted <= 1'b1;
          end else if (!bus.fetch_en) begin
            state <= IDLE;
          end
        end
        HALTED:  state <= HALTED;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.F_PC       = f_pc;
  assign bus.halted     = halted;
  assign bus.fifo_count = count;
  assign bus.out_valid  = out_valid;
  assign bus.out_pc     = out_valid ? mem_pc[rd_ptr]    : last_pc;
  assign bus.out_instr  = out_valid ? mem_instr[rd_ptr] : last_instr;
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: vector table plus hand sequences; delivered {pc, instr}
// pairs are checked against a queue of expected deliveries.
module tb_instr_fetch_ctrl;
  localparam int AW = 32;
  localparam int IW = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset_n;
  int   total = 0;
  int   passed = 0;
  logic halt_en = 1'b0;
  logic [AW-1:0] halt_pc = '0;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [IW-1:0] instr;
  } pair_t;

  typedef struct packed {
    logic          fe;
    logic          rdy;
    logic          rv;
    logic [AW-1:0] rpc;
    logic [AW-1:0] fpc;
    logic [2:0]    cnt;
    logic          val;
    logic          hlt;
  } vec_t;

  pair_t exp_q[$];
  vec_t  vecs[20];

  always #5 clk = ~clk;

  instr_fetch_ctrl_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .FIFO_DEPTH(DEPTH)) bus ();

  instr_fetch_ctrl #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .FIFO_DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Instruction memory model: mem[i] = i + 0x100, optional sentinel at halt_pc.
  assign bus.im_instr = (halt_en && bus.F_PC == halt_pc) ? 32'hFFFF_FFFF : bus.F_PC + 32'h100;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pc(input logic [AW-1:0] pc, input logic [IW-1:0] instr);
    pair_t p;
    p.pc = pc;
    p.instr = instr;
    exp_q.push_back(p);
  endtask

  // Handshake seen at the negedge is taken at the next rising edge.
  always @(negedge clk) begin
    if (reset_n && bus.out_valid && bus.out_ready && !bus.redirect_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_pop: got pc %0h, none expected", bus.out_pc);
      end else begin
        pair_t e;
        e = exp_q.pop_front();
        chk("pop_pc", 64'(bus.out_pc), 64'(e.pc));
        chk("pop_instr", 64'(bus.out_instr), 64'(e.instr));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //           fe    rdy   rv    rpc        fpc        cnt   val   hlt
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,     32'h0,     3'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,     32'h1,     3'd1, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,     32'h2,     3'd2, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,     32'h3,     3'd3, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,     32'h4,     3'd4, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,     32'h4,     3'd4, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 32'h0,     32'h5,     3'd4, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 32'h0,     32'h6,     3'd4, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'h0,     32'h7,     3'd4, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'h0,     32'h7,     3'd3, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0,     32'h7,     3'd3, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 32'h40,    32'h40,    3'd0, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 32'h0,     32'h41,    3'd1, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 32'h0,     32'h42,    3'd1, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 32'h0,     32'h43,    3'd1, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 32'h0,     32'h43,    3'd0, 1'b0, 1'b0};
    vecs[16] = '{1'b1, 1'b1, 1'b0, 32'h0,     32'h43,    3'd0, 1'b0, 1'b0};
    vecs[17] = '{1'b1, 1'b1, 1'b0, 32'h0,     32'h44,    3'd1, 1'b1, 1'b0};
    vecs[18] = '{1'b1, 1'b1, 1'b0, 32'h0,     32'h45,    3'd1, 1'b1, 1'b0};
    vecs[19] = '{1'b0, 1'b1, 1'b1, 32'h0,     32'h0,     3'd0, 1'b0, 1'b0};

    reset_n            = 1'b0;
    bus.fetch_en       = 1'b0;
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    step();
    step();
    chk("rst_fpc", 64'(bus.F_PC), 64'h0);
    chk("rst_cnt", 64'(bus.fifo_count), 64'h0);
    chk("rst_valid", 64'(bus.out_valid), 64'h0);
    chk("rst_instr", 64'(bus.out_instr), 64'h0);
    chk("rst_pc", 64'(bus.out_pc), 64'h0);
    chk("rst_halted", 64'(bus.halted), 64'h0);
    reset_n = 1'b1;
    step();

    // Deliveries: 0..3 before the flush, pcs 4..6 are flushed, then 0x40..0x43.
    for (int p = 0; p < 4; p++) expect_pc(AW'(p), IW'(p + 'h100));
    for (int p = 'h40; p <= 'h43; p++) expect_pc(AW'(p), IW'(p + 'h100));

    for (int i = 0; i < 20; i++) begin
      bus.fetch_en       = vecs[i].fe;
      bus.out_ready      = vecs[i].rdy;
      bus.redirect_valid = vecs[i].rv;
      bus.redirect_pc    = vecs[i].rpc;
      step();
      chk($sformatf("v%0d_fpc", i), 64'(bus.F_PC), 64'(vecs[i].fpc));
      chk($sformatf("v%0d_cnt", i), 64'(bus.fifo_count), 64'(vecs[i].cnt));
      chk($sformatf("v%0d_valid", i), 64'(bus.out_valid), 64'(vecs[i].val));
      chk($sformatf("v%0d_halted", i), 64'(bus.halted), 64'(vecs[i].hlt));
    end
    bus.redirect_valid = 1'b0;
    chk("table_queue_drained", 64'(exp_q.size()), 64'h0);
    exp_q.delete();

    // Halt on sentinel at pc 6.
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    halt_en = 1'b1;
    halt_pc = 32'h6;
    for (int p = 0; p < 6; p++) expect_pc(AW'(p), IW'(p + 'h100));
    expect_pc(32'h6, 32'hFFFF_FFFF);
    bus.fetch_en  = 1'b1;
    bus.out_ready = 1'b1;
    step();
    for (int k = 0; k < 30 && !bus.halted; k++) step();
    chk("halt_seen", 64'(bus.halted), 64'h1);
    chk("halt_fpc", 64'(bus.F_PC), 64'h7);
    step();
    step();
    step();
    chk("halted_fpc_hold", 64'(bus.F_PC), 64'h7);
    chk("halted_cnt", 64'(bus.fifo_count), 64'h0);
    chk("halted_stays", 64'(bus.halted), 64'h1);
    chk("halt_queue_drained", 64'(exp_q.size()), 64'h0);

    halt_en = 1'b0;
    expect_pc(32'h2, 32'h102);
    expect_pc(32'h3, 32'h103);
    expect_pc(32'h4, 32'h104);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h2;
    step();
    bus.redirect_valid = 1'b0;
    chk("resume_halted", 64'(bus.halted), 64'h0);
    chk("resume_fpc", 64'(bus.F_PC), 64'h2);
    chk("resume_valid", 64'(bus.out_valid), 64'h0);
    step();
    chk("resume_first_pc", 64'(bus.out_pc), 64'h2);
    chk("resume_fpc1", 64'(bus.F_PC), 64'h3);
    step();
    bus.fetch_en = 1'b0;
    step();
    step();
    chk("resume_fpc_hold", 64'(bus.F_PC), 64'h5);
    chk("resume_cnt", 64'(bus.fifo_count), 64'h0);
    chk("resume_queue_drained", 64'(exp_q.size()), 64'h0);

    // Asynchronous reset with two entries queued.
    bus.out_ready = 1'b0;
    bus.fetch_en  = 1'b1;
    step();
    step();
    step();
    chk("pre_areset_cnt", 64'(bus.fifo_count), 64'h2);
    #3 reset_n = 1'b0;
    #1;
    chk("areset_valid", 64'(bus.out_valid), 64'h0);
    chk("areset_fpc", 64'(bus.F_PC), 64'h0);
    chk("areset_halted", 64'(bus.halted), 64'h0);
    chk("areset_cnt", 64'(bus.fifo_count), 64'h0);
    step();
    step();
    chk("areset_hold_fpc", 64'(bus.F_PC), 64'h0);
    chk("areset_hold_valid", 64'(bus.out_valid), 64'h0);
    bus.fetch_en = 1'b0;
    reset_n = 1'b1;
    step();
    chk("post_areset_fpc", 64'(bus.F_PC), 64'h0);
    chk("post_areset_cnt", 64'(bus.fifo_count), 64'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
